nn_pix_loader: RTL

NN_PIX_LOADER -- requirements
Module: nn_pix_loader

---
 rtl/nn_pix_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/nn_pix_loader.sv
// ============================================================================
// Module   : nn_pix_loader
// Purpose  : Streams N_IN pixel bytes into an inference core, pulses start,
//            waits for done (with timeout) and hands the result out.
//            Optional macro NN_PIX_LOADER_TLAST_CHECK_EN enables s_last checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nn_pix_loader #(
  parameter int N_IN    = 784,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       pix_we,
  output logic [9:0] pix_addr,
  output logic [7:0] pix_data,
  output logic       start,
  input  logic       done,
  input  logic [3:0] predicted,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [3:0] result,
  output logic       err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;

  localparam logic [9:0]    LAST_IDX  = 10'(N_IN - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [9:0]    r_cnt;
  logic [WW-1:0] r_wcnt;
  logic          r_s_ready;
  logic          r_pix_we;
  logic [9:0]    r_pix_addr;
  logic [7:0]    r_pix_data;
  logic          r_start;
  logic          r_result_valid;
  logic [3:0]    r_result;
  logic          r_err;

  logic w_acc;
  logic w_final;
  logic w_tlast_err;
  logic w_tlast_abort;

  assign w_acc   = s_valid & r_s_ready;
  assign w_final = (r_cnt == LAST_IDX);

`ifdef NN_PIX_LOADER_TLAST_CHECK_EN
  // s_last must mark exactly the final beat; an early s_last abandons the frame
  assign w_tlast_err   = w_acc & (s_last != w_final);
  assign w_tlast_abort = w_acc & s_last & ~w_final;
`else
  logic w_unused_last;
  assign w_unused_last = s_last;
  assign w_tlast_err   = 1'b0;
  assign w_tlast_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_wcnt         <= '0;
      r_s_ready      <= 1'b0;
      r_pix_we       <= 1'b0;
      r_pix_addr     <= '0;
      r_pix_data     <= '0;
      r_start        <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_err          <= 1'b0;
    end else begin
      r_pix_we <= 1'b0;
      r_start  <= 1'b0;
      if (clear) begin
        r_state        <= IDLE;
        r_cnt          <= '0;
        r_wcnt         <= '0;
        r_s_ready      <= 1'b1;
        r_result_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE, LOAD: begin
            r_s_ready <= 1'b1;
            if (w_acc) begin
              r_pix_we   <= 1'b1;
              r_pix_addr <= r_cnt;
              r_pix_data <= s_data;
              if (r_state == IDLE) r_err <= 1'b0;
              if (w_tlast_err) r_err <= 1'b1;
              if (w_tlast_abort) begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end else if (w_final) begin
                r_state   <= START;
                r_cnt     <= '0;
                r_s_ready <= 1'b0;
              end else begin
                r_state <= LOAD;
                r_cnt   <= r_cnt + 10'd1;
              end
            end
          end
          // The final write is visible while in START, so the pulse lands one cycle later
          START: begin
            r_start <= 1'b1;
            r_wcnt  <= '0;
            r_state <= WAIT;
          end
          WAIT: begin
            if (done) begin
              r_result       <= predicted;
              r_result_valid <= 1'b1;
              r_state        <= RESULT;
            end else if (r_wcnt == WAIT_LAST) begin
              r_result       <= 4'hF;
              r_err          <= 1'b1;
              r_result_valid <= 1'b1;
              r_state        <= RESULT;
            end else begin
              r_wcnt <= r_wcnt + WW'(1);
            end
          end
          RESULT: begin
            if (r_result_valid && result_ready) begin
              r_result_valid <= 1'b0;
              r_s_ready      <= 1'b1;
              r_state        <= IDLE;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_s_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign s_ready      = r_s_ready;
  assign pix_we       = r_pix_we;
  assign pix_addr     = r_pix_addr;
  assign pix_data     = r_pix_data;
  assign start        = r_start;
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign err          = r_err;

endmodule

`default_nettype wire
